search_pipe_arb: RTL and testbench



---
 rtl/search_pipe_arb_pkg.sv | 14 +
 rtl/search_rr_arb2.sv | 36 +++
 rtl/search_pipe_arb.sv | 106 ++++++++++
 tb/tb_search_pipe_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/search_pipe_arb_pkg.sv
// Shared types and constants for the search_pipe_arb pipeline.
package search_pipe_arb_pkg;

  localparam int unsigned DATA_W = 8;   // stage data width; top WIDTH must match
  localparam int unsigned DEPTH  = 3;   // launch, capture, output
  localparam int unsigned STAT_W = 16;  // grant counter width

  typedef struct packed {
    logic              valid;
    logic              src;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/search_rr_arb2.sv
// Two-way round-robin arbiter. The pointer favours one requester on a tie and
// flips to the other requester after every accepted grant.
module search_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  // Grant selection and pointer next-state
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
    if (en && (|gnt)) begin
      prio_d = ~gnt[1];
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/search_pipe_arb.sv
// Round-robin arbiter feeding a three-stage launch/capture/output pipeline
// with valid/ready backpressure and bubble collapse.
// Optional build macro SEARCH_PIPE_ARB_STATS_EN adds saturating grant counters.
module search_pipe_arb
  import search_pipe_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             busy
`ifdef SEARCH_PIPE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  stage_t [DEPTH-1:0] stg_q, stg_d;
  logic   [DEPTH-1:0] adv;
  logic   [1:0]       gnt;
  logic               acc;
  logic               gsel;
  logic               arb_en;

  // Ready chain from the output back to the launch stage; no dependence on req_valid
  always_comb begin
    adv[2] = out_ready || !stg_q[2].valid;
    adv[1] = adv[2]    || !stg_q[1].valid;
    adv[0] = adv[1]    || !stg_q[0].valid;
  end

  // Ready is held low while reset is asserted even though the empty pipe would advance
  assign arb_en    = adv[0] && !rst;
  assign req_ready = arb_en ? gnt : 2'b00;
  assign acc       = |req_ready;
  assign gsel      = gnt[1];

  search_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Stage shift: each stage loads its predecessor when it advances, else holds
  always_comb begin
    stg_d = stg_q;
    if (adv[2]) stg_d[2] = stg_q[1];
    if (adv[1]) stg_d[1] = stg_q[0];
    if (adv[0]) begin
      stg_d[0].valid = acc;
      stg_d[0].src   = acc ? gsel : 1'b0;
      stg_d[0].data  = acc ? req_data[gsel*WIDTH +: WIDTH] : '0;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_valid = stg_q[2].valid;
  assign out_data  = stg_q[2].data;
  assign out_src   = stg_q[2].src;
  assign busy      = stg_q[0].valid || stg_q[1].valid || stg_q[2].valid;

`ifdef SEARCH_PIPE_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-requester accept counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req_ready[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (req_ready[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_search_pipe_arb.sv
// Scoreboard bench for search_pipe_arb with a word-position reference model.
module tb_search_pipe_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [2*W-1:0] req_data;
  logic [1:0]   req_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         busy;
`ifdef SEARCH_PIPE_ARB_STATS_EN
  logic [15:0]  gnt_cnt0, gnt_cnt1;
`endif

  search_pipe_arb #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
`ifdef SEARCH_PIPE_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         src;
  } exp_t;

  typedef struct {
    logic [W-1:0] data;
    logic         src;
    int           pos;   // 0 = launch, 2 = output
  } word_t;

  exp_t  exp_q[$];
  word_t pipe[$];
  bit    m_prio;
  int    m_cnt0, m_cnt1;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One bus cycle: drive, compare combinational outputs, then advance the model
  task automatic cycle(input logic [1:0] rv, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic ordy);
    logic [1:0] exp_rdy;
    logic       g;
    bit         acc, full, ov;
    int         limit, np;
    @(negedge clk);
    req_valid = rv;
    req_data  = {d1, d0};
    out_ready = ordy;
    g    = (rv == 2'b11) ? m_prio : rv[1];
    full = (pipe.size() == 3) && !ordy;
    acc  = (rv != 2'b00) && !full;
    exp_rdy = acc ? (2'b01 << g) : 2'b00;
    ov   = (pipe.size() > 0) && (pipe[0].pos == 2);
    #1;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
    chk("busy", {31'd0, busy}, {31'd0, pipe.size() > 0});
    @(posedge clk);
    if (ov && ordy) void'(pipe.pop_front());
    limit = 2;
    foreach (pipe[i]) begin
      np = (pipe[i].pos + 1 < limit) ? pipe[i].pos + 1 : limit;
      pipe[i].pos = np;
      limit = np - 1;
    end
    if (acc) begin
      pipe.push_back('{data: (g ? d1 : d0), src: g, pos: 0});
      exp_q.push_back('{data: (g ? d1 : d0), src: g});
      m_prio = ~g;
      if (g) m_cnt1++; else m_cnt0++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_valid = 2'b11;
    pipe.delete();
    exp_q.delete();
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (5) cycle(2'b00, '0, '0, 1'b1);
    chk("drained", exp_q.size(), 32'd0);
  endtask

  // Monitor: compare every presented output word against the scoreboard head
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].data});
        chk("out_src", {31'd0, out_src}, {31'd0, exp_q[0].src});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_data = '0;
    out_ready = 1'b1;
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    do_reset();

    // Alternation under continuous requests
    repeat (6) cycle(2'b11, 8'hA0, 8'hB0, 1'b1);
    drain();

    // Backpressure fill: fourth word waits until the output drains
    cycle(2'b01, 8'h01, 8'h00, 1'b0);
    cycle(2'b01, 8'h02, 8'h00, 1'b0);
    cycle(2'b01, 8'h03, 8'h00, 1'b0);
    cycle(2'b01, 8'h04, 8'h00, 1'b0);
    cycle(2'b01, 8'h04, 8'h00, 1'b1);
    drain();

    // Bubble collapse under a stall
    cycle(2'b01, 8'h55, 8'h00, 1'b1);
    cycle(2'b00, 8'h00, 8'h00, 1'b0);
    cycle(2'b01, 8'h66, 8'h00, 1'b0);
    repeat (3) cycle(2'b00, 8'h00, 8'h00, 1'b0);
    drain();

    // Reset with all three stages occupied
    cycle(2'b01, 8'h11, 8'h00, 1'b0);
    cycle(2'b10, 8'h00, 8'h22, 1'b0);
    cycle(2'b01, 8'h33, 8'h00, 1'b0);
    do_reset();
    cycle(2'b10, 8'h00, 8'h77, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

`ifdef SEARCH_PIPE_ARB_STATS_EN
    do_reset();
    repeat (5) cycle(2'b01, 8'h5A, 8'h00, 1'b1);
    repeat (3) cycle(2'b10, 8'h00, 8'hA5, 1'b1);
    drain();
    chk("gnt_cnt0", {16'd0, gnt_cnt0}, m_cnt0);
    chk("gnt_cnt1", {16'd0, gnt_cnt1}, m_cnt1);
    repeat (70000) cycle(2'b01, 8'h01, 8'h00, 1'b1);
    drain();
    chk("gnt_cnt0_sat", {16'd0, gnt_cnt0}, (m_cnt0 > 65535) ? 32'hFFFF : m_cnt0);
    chk("gnt_cnt1_hold", {16'd0, gnt_cnt1}, m_cnt1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
